// File: rtl/spi_responder.sv
// SPI mode-3 register-device model sharing clk with the initiator: 16-bit R/W frames, local load port.
// Optional macro SPI_RESPONDER_AUTOINC_EN enables multi-byte bursts at incrementing addresses.
module spi_responder #(
  parameter int         ADDR_BITS = 4,
  parameter logic [7:0] WHO_AM_I  = 8'h33
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SPC,
  input  logic                 CS,
  input  logic                 SDI,
  output logic                 SDO,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  localparam int         NREGS    = 1 << ADDR_BITS;
  localparam logic [6:0] WHO_ADDR = 7'h0F;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t     state;
  logic       spc_q;
  logic [4:0] bitcnt;
  logic [6:0] hdr_sr;
  logic       rw;
  logic [6:0] addr;
  logic [6:0] data_sr;
  logic [6:0] out_sr;
  logic [7:0] regs [NREGS];

  logic       rise, fall, last_data_edge, spi_we;
  logic       rw_new;
  logic [6:0] addr_new, lookup_addr;
  logic [7:0] data_new, rd_val;

  assign rise           = SPC & ~spc_q & ~CS;
  assign fall           = ~SPC & spc_q & ~CS;
  assign rw_new         = hdr_sr[6];
  assign addr_new       = {hdr_sr[5:0], SDI};
  assign data_new       = {data_sr, SDI};
  assign last_data_edge = rise && (state == DATA) && (bitcnt == 5'd15);
  assign spi_we         = last_data_edge && !rw && ((addr >> ADDR_BITS) == 7'd0)
                          && (addr != WHO_ADDR);

  // At the end of the header the address is still being shifted in, so look it up directly;
  // during a data byte the next lookup is the following (burst) address.
  assign lookup_addr = (state == DATA) ? addr + 7'd1 : addr_new;

  always_comb begin
    rd_val = 8'h00;
    if (lookup_addr == WHO_ADDR)
      rd_val = WHO_AM_I;
    else if ((lookup_addr >> ADDR_BITS) == 7'd0)
      rd_val = regs[lookup_addr[ADDR_BITS-1:0]];
  end

  // SPI commit is placed after the local load so it wins on a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      if (load_en && (7'(load_addr) != WHO_ADDR))
        regs[load_addr] <= load_data;
      if (spi_we)
        regs[addr[ADDR_BITS-1:0]] <= data_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spc_q     <= 1'b1;
      state     <= IDLE;
      bitcnt    <= 5'd0;
      hdr_sr    <= 7'd0;
      rw        <= 1'b0;
      addr      <= 7'd0;
      data_sr   <= 7'd0;
      out_sr    <= 7'd0;
      SDO       <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      spc_q     <= SPC;
      busy      <= ~CS;
      wr_strobe <= 1'b0;
      if (last_data_edge && !rw) begin
        wr_strobe <= 1'b1;
        wr_addr   <= addr;
        wr_data   <= data_new;
      end
      if (CS) begin
        state  <= IDLE;
        bitcnt <= 5'd0;
        SDO    <= 1'b0;
      end else begin
        case (state)
          IDLE, ADDR: begin
            state <= ADDR;
            if (rise) begin
              hdr_sr <= addr_new;
              bitcnt <= bitcnt + 5'd1;
              if (bitcnt == 5'd7) begin
                rw    <= rw_new;
                addr  <= addr_new;
                state <= DATA;
                if (rw_new) begin
                  out_sr <= rd_val[6:0];
                  SDO    <= rd_val[7];
                end
              end
            end
          end
          DATA: begin
            if (rise) begin
              data_sr <= data_new[6:0];
              if (bitcnt == 5'd15) begin
`ifdef SPI_RESPONDER_AUTOINC_EN
                addr   <= addr + 7'd1;
                bitcnt <= 5'd8;
                if (rw) begin
                  out_sr <= rd_val[6:0];
                  SDO    <= rd_val[7];
                end
`else
                state  <= DONE;
                bitcnt <= bitcnt + 5'd1;
                SDO    <= 1'b0;
`endif
              end else begin
                bitcnt <= bitcnt + 5'd1;
              end
            end else if (fall && rw) begin
              // Zero fill makes SDO fall to 0 once bit 0 has been shifted out.
              out_sr <= {out_sr[5:0], 1'b0};
              SDO    <= out_sr[6];
            end
          end
          DONE:    SDO   <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
